// File: rtl/serializer_frame_tx.sv
// UART frame serializer: start, DATA_WIDTH data bits, optional parity, 1 or 2 stop bits.
// One-word holding register lets the next frame start right after the last stop bit.
module serializer_frame_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  stop2,
    input  logic                  msb_first,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                state, next_state;
    logic                  load;
    logic                  final_stop;

    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_valid;
    logic                  hold_par_en, hold_par_odd, hold_stop2, hold_msb;

    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         cnt;
    logic                  cfg_par_en, cfg_stop2, cfg_msb;
    logic                  par_bit;

    assign in_ready   = !hold_valid;
    assign final_stop = (state == STOP1 && !cfg_stop2) || (state == STOP2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load       = 1'b1;
                    next_state = START;
                end
            end
            START:  next_state = DATA;
            DATA: begin
                if (cnt == CW'(DATA_WIDTH - 1))
                    next_state = cfg_par_en ? PARITY : STOP1;
            end
            PARITY: next_state = STOP1;
            STOP1, STOP2: begin
                if (state == STOP1 && cfg_stop2) begin
                    next_state = STOP2;
                end else if (hold_valid) begin
                    load       = 1'b1;
                    next_state = START;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Holding register; load and accept are mutually exclusive because load needs hold_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data    <= '0;
            hold_valid   <= 1'b0;
            hold_par_en  <= 1'b0;
            hold_par_odd <= 1'b0;
            hold_stop2   <= 1'b0;
            hold_msb     <= 1'b0;
        end else if (in_valid && !hold_valid) begin
            hold_data    <= in_data;
            hold_valid   <= 1'b1;
            hold_par_en  <= par_en;
            hold_par_odd <= par_odd;
            hold_stop2   <= stop2;
            hold_msb     <= msb_first;
        end else if (load) begin
            hold_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift      <= '0;
            cnt        <= '0;
            cfg_par_en <= 1'b0;
            cfg_stop2  <= 1'b0;
            cfg_msb    <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            if (load) begin
                shift      <= hold_data;
                cfg_par_en <= hold_par_en;
                cfg_stop2  <= hold_stop2;
                cfg_msb    <= hold_msb;
                par_bit    <= (^hold_data) ^ hold_par_odd;
            end else if (state == DATA) begin
                shift <= cfg_msb ? (shift << 1) : (shift >> 1);
            end

            if (state == START)
                cnt <= '0;
            else if (state == DATA)
                cnt <= cnt + CW'(1);
        end
    end

    // Outputs decode purely from state registers, so reset forces them immediately.
    always_comb begin
        tx_out = 1'b1;
        case (state)
            START:   tx_out = 1'b0;
            DATA:    tx_out = cfg_msb ? shift[DATA_WIDTH-1] : shift[0];
            PARITY:  tx_out = par_bit;
            default: tx_out = 1'b1;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = final_stop;

endmodule

// File: tb/tb_serializer_frame_tx.sv
// Directed bench for serializer_frame_tx at DATA_WIDTH 8, 1 and 16.
module tb_serializer_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        par_en, par_odd, stop2, msb_first;
    logic [1:0]  sel;

    logic rdy8, tx8, busy8, fd8;
    logic rdy1, tx1, busy1, fd1;
    logic rdy16, tx16, busy16, fd16;
    logic rdy, tx, busy, fd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serializer_frame_tx #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid && sel == 2'd0),
        .in_ready(rdy8), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
        .msb_first(msb_first), .tx_out(tx8), .busy(busy8), .frame_done(fd8));

    serializer_frame_tx #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[0:0]), .in_valid(in_valid && sel == 2'd1),
        .in_ready(rdy1), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
        .msb_first(msb_first), .tx_out(tx1), .busy(busy1), .frame_done(fd1));

    serializer_frame_tx #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_data(in_data[15:0]), .in_valid(in_valid && sel == 2'd2),
        .in_ready(rdy16), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
        .msb_first(msb_first), .tx_out(tx16), .busy(busy16), .frame_done(fd16));

    always_comb begin
        rdy = rdy8; tx = tx8; busy = busy8; fd = fd8;
        if (sel == 2'd1) begin
            rdy = rdy1; tx = tx1; busy = busy1; fd = fd1;
        end else if (sel == 2'd2) begin
            rdy = rdy16; tx = tx16; busy = busy16; fd = fd16;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic pe, input logic po, input logic s2, input logic msb);
        par_en = pe; par_odd = po; stop2 = s2; msb_first = msb;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (rdy !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready"}, rdy, 1);
    endtask

    // Expected strings list one character per cycle, starting at the START cycle.
    task automatic stream(input string tag, input string txe, input string fde);
        for (int i = 0; i < txe.len(); i++) begin
            check($sformatf("%s tx[%0d]", tag, i), tx, txe[i] == 8'd49);
            check($sformatf("%s done[%0d]", tag, i), fd, fde[i] == 8'd49);
            check($sformatf("%s busy[%0d]", tag, i), busy, 1);
            @(posedge clk); #1;
        end
        check({tag, " idle tx"}, tx, 1);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle done"}, fd, 0);
    endtask

    task automatic single(input string tag, input logic [31:0] d, input string txe, input string fde);
        in_data  = d;
        in_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " pre-load tx"}, tx, 1);
        check({tag, " pre-load busy"}, busy, 0);
        check({tag, " pre-load ready"}, rdy, 0);
        @(posedge clk); #1;
        stream(tag, txe, fde);
    endtask

    // Second word is presented with cfg2 and the pins then change to cfg3 mid-frame.
    task automatic back2back(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [3:0] cfg2, input logic [3:0] cfg3, input int n1,
                             input string txe, input string fde);
        in_data  = d1;
        in_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk); #1;
        in_data = d2;
        set_cfg(cfg2[0], cfg2[1], cfg2[2], cfg2[3]);
        @(posedge clk); #1;
        check({tag, " ready after load"}, rdy, 1);
        fork
            stream(tag, txe, fde);
            begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                set_cfg(cfg3[0], cfg3[1], cfg3[2], cfg3[3]);
                for (int k = 1; k < n1; k++) begin
                    check($sformatf("%s held ready[%0d]", tag, k), rdy, 0);
                    @(posedge clk); #1;
                end
                check({tag, " ready after 2nd load"}, rdy, 1);
            end
        join
    endtask

    task automatic reset_mid(input string tag, input logic [31:0] d1, input logic [31:0] d2);
        in_data  = d1;
        in_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk); #1;
        in_data = d2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " word held"}, rdy, 0);
        #3 rst = 1'b0;
        #1;
        check({tag, " rst tx"}, tx, 1);
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst done"}, fd, 0);
        @(negedge clk);
        rst = 1'b1;
        check({tag, " ready after release"}, rdy, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s post tx[%0d]", tag, k), tx, 1);
            check($sformatf("%s post busy[%0d]", tag, k), busy, 0);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        sel      = 2'd0;
        set_cfg(0, 0, 0, 0);
        #1;
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", fd, 0);
        check("reset ready", rdy, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        single("8n1_a5", 32'hA5, "0101001011", "0000000001");
        set_cfg(1, 0, 0, 0);
        single("par_even_a5", 32'hA5, "01010010101", "00000000001");
        set_cfg(1, 1, 0, 0);
        single("par_odd_a5", 32'hA5, "01010010111", "00000000001");
        set_cfg(1, 0, 0, 0);
        single("par_even_01", 32'h01, "01000000011", "00000000001");
        set_cfg(0, 0, 1, 1);
        single("msb_2stop_a5", 32'hA5, "01010010111", "00000000001");

        set_cfg(0, 0, 0, 0);
        back2back("b2b", 32'h55, 32'h0F, 4'b0000, 4'b0000, 10,
                  "01010101010111100001", "00000000010000000001");
        // cfg bits are {msb_first, stop2, par_odd, par_en}
        set_cfg(0, 0, 0, 0);
        back2back("cfg_iso", 32'hA5, 32'h01, 4'b1101, 4'b0000, 10,
                  "0101001011000000001111", "0000000001000000000001");

        reset_mid("rst8", 32'hA5, 32'h3C);

        sel = 2'd1;
        set_cfg(0, 0, 0, 0);
        single("w1", 32'h1, "011", "001");
        reset_mid("rst1", 32'h0, 32'h1);

        sel = 2'd2;
        single("w16", 32'hBEEF, "011110111011111011", "000000000000000001");
        reset_mid("rst16", 32'hBEEF, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/serializer_frame_tx.md
# serializer_frame_tx

Parametrised frame serializer for the UART transmit path. It accepts DATA_WIDTH-bit words through a valid/ready handshake and buffers one word in a holding register while the previous word is still shifting. It emits one complete frame per word: start bit, data bits, optional parity, then one or two stop bits. One bit is sent per clk cycle, where clk is the baud-tick clock domain. It replaces the fixed 8-bit shift/count serializer with an integrated framing FSM, bit-order control and back-to-back frame streaming.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 1..32.
- rst  input  1  asynchronous active-low reset
- clk  input  1  baud-rate clock; one frame bit per rising edge
- in_data  input  DATA_WIDTH  word to transmit
- in_valid  input  1  in_data is valid
- in_ready  output  1  holding register empty; transfer occurs when in_valid && in_ready at a rising edge
- par_en  input  1  1 = append parity bit
- par_odd  input  1  0 = even parity, 1 = odd parity
- stop2  input  1  0 = one stop bit, 1 = two stop bits
- msb_first  input  1  0 = LSB first, 1 = MSB first
- tx_out  output  1  serial line; idles high
- busy  output  1  high whenever the FSM is not in IDLE
- frame_done  output  1  one-cycle pulse during the final stop-bit cycle

## Operation
- **Holding register** (hold_data, hold_cfg, hold_valid):
  - in_ready = !hold_valid.
  - On an accepted transfer, capture in_data together with par_en, par_odd, stop2 and msb_first; set hold_valid.
- **Load.** In IDLE with hold_valid=1, or in the final stop-bit cycle with hold_valid=1, the next edge performs a load:
  - Copy the holding register to the shift register and the active config.
  - Compute the parity bit: XOR of the data, inverted when par_odd=1.
  - Clear hold_valid and enter START.
- **Simultaneous load and accept.** in_ready is low while hold_valid=1, so the holding register never loads and accepts on the same edge. A new word is accepted at the earliest one cycle after the load.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: tx_out=1. Go to START on load, otherwise stay.
  - START: tx_out=0. Go to DATA; the bit counter clears to 0.
  - DATA: tx_out = shift[0] (LSB first) or shift[DATA_WIDTH-1] (MSB first). Shift by one position per cycle, right for LSB first and left for MSB first.
    - The counter increments each cycle.
    - When counter == DATA_WIDTH-1, go to PARITY if par_en, otherwise STOP1.
  - PARITY: tx_out = parity bit. Go to STOP1.
  - STOP1: tx_out=1. If stop2, go to STOP2. Otherwise load and go to START if hold_valid, else go to IDLE.
  - STOP2: tx_out=1. Load and go to START if hold_valid, else go to IDLE.
- **Counter width:** $clog2(DATA_WIDTH+1) bits, so DATA_WIDTH=1 is legal. The counter never wraps mid-frame.
- **Config source.** Active config comes only from the copy latched at load. Changes on the config pins after acceptance affect only later words.
- **Output timing.** tx_out, busy and frame_done decode from registers only. There is no combinational path from inputs to outputs.
- **Reset values:** state=IDLE, tx_out=1, busy=0, frame_done=0, in_ready=1, hold_valid=0, shift register and counter=0.

## Timing
- **Frame length** = 1 + DATA_WIDTH + par_en + 1 + stop2 cycles.
- **Latency from IDLE:** if a word is accepted at edge N, the load happens at edge N+1 and START (tx_out=0) is driven from edge N+1.
- **Back-to-back frames:** no idle cycle between frames when a word is held at the final stop bit. The next START follows the last stop bit directly.
- **busy** rises with the START cycle and falls on entry to IDLE. It stays high across back-to-back frames.
- **frame_done** is high for exactly the final stop-bit cycle: STOP1 when stop2=0, STOP2 when stop2=1.
- **Reset asserted mid-frame:**
  - tx_out goes to 1 and busy/frame_done go to 0 immediately (asynchronously).
  - The held word is discarded; no partial frame resumes.
- **in_valid without acceptance:** held high while in_ready=0, it causes no state change. The word transfers on the first edge where in_ready=1.

## Test plan
- **8N1, LSB first, even:** in_data=0xA5, par_en=0, stop2=0. Required tx_out from START: 0,1,0,1,0,0,1,0,1,1 (10 cycles), then idle high. frame_done pulses once, in cycle 10.
- **Parity, 8 bits:** 0xA5 with par_en=1.
  - par_odd=0: parity bit 0, 11-cycle frame.
  - par_odd=1: parity bit 1.
  - 0x01 with even parity: parity bit 1.
- **MSB first with 2 stop bits:** DATA_WIDTH=8, 0xA5, msb_first=1, stop2=1. Required tx_out: 0,1,0,1,0,0,1,0,1,1,1. frame_done is high only in the second stop cycle.
- **Back-to-back:** present 0x55 then 0x0F with in_valid held high.
  - The second word is accepted during the first frame.
  - The second START immediately follows the first stop bit.
  - busy stays continuously high for 20 cycles.
  - in_ready is low from the second acceptance until the second load.
- **Config isolation:** toggle par_en, stop2 and msb_first during an active frame. The frame in flight is unchanged, and the held word uses the config captured at its acceptance.
- **Reset mid-frame, plus width corner:** assert rst in the DATA state. tx_out=1 and busy=0 at once, in_ready=1 after release. Repeat with DATA_WIDTH=1 and DATA_WIDTH=16 (0xBEEF): frame lengths are 3 and 18 cycles respectively (par_en=0, stop2=0).
